ex_mem_reg: RTL
===============

Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage and the MEM stage.
- Captures the EX result bundle each cycle and presents it to MEM one cycle later.
- Inserts bubbles on EX stall and holds on MEM stall.
- Preserves multi-cycle multiply-accumulate temporaries (partial HI/LO and step count) across EX stall cycles.
- Counts inserted bubbles for performance monitoring.

Parameters:
- BUB_W, 16, width of the saturating bubble counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- flush  input  1  discard the in-flight instruction, load NOP
- ex_stall  input  1  EX stage stalled this cycle
- mem_stall  input  1  MEM stage stalled this cycle
- ex_wd  input  5  EX destination register address
- ex_wreg  input  1  EX register write enable
- ex_wdata  input  32  EX result
- ex_whilo  input  1  EX HI/LO write enable
- ex_hi  input  32  EX HI result
- ex_lo  input  32  EX LO result
- hilo_tmp_i  input  64  EX partial accumulate product
- cnt_i  input  2  EX accumulate step count
- mem_wd  output  5  to MEM: destination address
- mem_wreg  output  1  to MEM: write enable
- mem_wdata  output  32  to MEM: result
- mem_whilo  output  1  to MEM: HI/LO write enable
- mem_hi  output  32  to MEM: HI value
- mem_lo  output  32  to MEM: LO value
- hilo_tmp_o  output  64  back to EX: held partial product
- cnt_o  output  2  back to EX: held step count
- bubble_cnt  output  BUB_W  bubbles inserted since reset, saturating

Behaviour:
- All outputs are registered and update only on the rising edge of clk. Latency EX to MEM is 1 cycle.
- NOP bundle: mem_wd=5'd0, mem_wreg=0, mem_wdata=0, mem_whilo=0, mem_hi=0, mem_lo=0.
- Update cases, evaluated per edge in priority order:
  1. rst=1: NOP bundle; hilo_tmp_o=0; cnt_o=0; bubble_cnt=0. Overrides all other inputs, including an in-progress accumulate.
  2. flush=1: NOP bundle; hilo_tmp_o=0; cnt_o=0; bubble_cnt unchanged. Flush wins over any stall combination.
  3. ex_stall=1, mem_stall=0 (bubble): NOP bundle; hilo_tmp_o<=hilo_tmp_i; cnt_o<=cnt_i; bubble_cnt increments by 1 and saturates at all-ones.
  4. mem_stall=1, either ex_stall value (hold): all mem_* hold; hilo_tmp_o and cnt_o hold; bubble_cnt unchanged. The controller never produces ex_stall=0 with mem_stall=1; the block still treats that combination as a hold, with no data loss.
  5. ex_stall=0, mem_stall=0 (advance): mem_* <= ex_*; hilo_tmp_o<=0; cnt_o<=0; bubble_cnt unchanged.
- Accumulate flow:
  - EX stalls itself for the first step and drives hilo_tmp_i and cnt_i=2'b01.
  - The block returns these values on hilo_tmp_o and cnt_o in the next cycle.
  - EX finishes on the following cycle and releases the stall; the advance clears the temporaries.
- No combinational path exists from any input to any output.
- bubble_cnt saturation: at all-ones a further bubble leaves it at all-ones, with no wrap.

Test Plan:
- Reset: drive all inputs nonzero with rst=1 for 2 cycles -> every output 0, including bubble_cnt=0. Then rst=0 with stalls=0 -> next edge mem_* equal the ex_* inputs.
- Advance: ex_wd=5'd3, ex_wreg=1, ex_wdata=32'hDEADBEEF, ex_whilo=1, ex_hi=32'h1, ex_lo=32'h2 -> one edge later mem_* carry exactly these values; hilo_tmp_o=0; cnt_o=0.
- Accumulate bubble: ex_stall=1, hilo_tmp_i=64'h0000_0001_FFFF_FFFF, cnt_i=1 -> next edge mem_wreg=0, hilo_tmp_o=64'h0000_0001_FFFF_FFFF, cnt_o=1, bubble_cnt=1. Release ex_stall -> temporaries return to 0 and mem_* carry the final result.
- Hold: load ex_wdata=32'hA5A5A5A5, then assert ex_stall=1 and mem_stall=1 for 3 cycles while the ex_* inputs change -> mem_wdata stays 32'hA5A5A5A5 and bubble_cnt is unchanged.
- Flush priority: flush=1 together with ex_stall=1 and mem_stall=1, hilo_tmp_i nonzero -> NOP bundle, hilo_tmp_o=0, cnt_o=0, bubble_cnt unchanged.
- Saturation: run with BUB_W=4 and apply 17 bubble cycles -> bubble_cnt reaches 4'hF at the 15th bubble and stays 4'hF.

Source files
------------

// File: rtl/ex_mem_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ex_mem_if : EX-to-MEM bundle, stall/flush control, accumulate loop   |
// | Revision  : 1.0                                                      |
// +--------------------------------------------------------------------+
interface ex_mem_if #(
   parameter int BUB_W = 16
);
   logic              flush;
   logic              ex_stall;
   logic              mem_stall;
   logic [4:0]        ex_wd;
   logic              ex_wreg;
   logic [31:0]       ex_wdata;
   logic              ex_whilo;
   logic [31:0]       ex_hi;
   logic [31:0]       ex_lo;
   logic [63:0]       hilo_tmp_i;
   logic [1:0]        cnt_i;
   logic [4:0]        mem_wd;
   logic              mem_wreg;
   logic [31:0]       mem_wdata;
   logic              mem_whilo;
   logic [31:0]       mem_hi;
   logic [31:0]       mem_lo;
   logic [63:0]       hilo_tmp_o;
   logic [1:0]        cnt_o;
   logic [BUB_W-1:0]  bubble_cnt;

   modport master (
      output flush, ex_stall, mem_stall, ex_wd, ex_wreg, ex_wdata, ex_whilo,
             ex_hi, ex_lo, hilo_tmp_i, cnt_i,
      input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
             hilo_tmp_o, cnt_o, bubble_cnt
   );

   modport slave (
      input  flush, ex_stall, mem_stall, ex_wd, ex_wreg, ex_wdata, ex_whilo,
             ex_hi, ex_lo, hilo_tmp_i, cnt_i,
      output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
             hilo_tmp_o, cnt_o, bubble_cnt
   );
endinterface
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ex_mem_reg : EX/MEM pipeline register with bubble/hold/flush control |
// | Revision   : 1.0                                                     |
// +--------------------------------------------------------------------+
module ex_mem_reg #(
   parameter int BUB_W = 16
) (
   input  wire logic  clk,
   input  wire logic  rst,
   ex_mem_if.slave    bus
);
   logic [4:0]        r_wd;
   logic              r_wreg;
   logic [31:0]       r_wdata;
   logic              r_whilo;
   logic [31:0]       r_hi;
   logic [31:0]       r_lo;
   logic [63:0]       r_hilo_tmp;
   logic [1:0]        r_cnt;
   logic [BUB_W-1:0]  r_bub;

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         r_wd       <= 5'd0;
         r_wreg     <= 1'b0;
         r_wdata    <= 32'd0;
         r_whilo    <= 1'b0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
         r_hilo_tmp <= 64'd0;
         r_cnt      <= 2'd0;
         if (rst)
            r_bub <= '0;
      end else if (bus.mem_stall) begin
         // MEM cannot accept: everything holds, whatever EX is doing
         r_wd       <= r_wd;
      end else if (bus.ex_stall) begin
         // Bubble: NOP to MEM, accumulate temporaries looped back to EX
         r_wd       <= 5'd0;
         r_wreg     <= 1'b0;
         r_wdata    <= 32'd0;
         r_whilo    <= 1'b0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
         r_hilo_tmp <= bus.hilo_tmp_i;
         r_cnt      <= bus.cnt_i;
         if (r_bub != '1)
            r_bub <= r_bub + 1'b1;
      end else begin
         r_wd       <= bus.ex_wd;
         r_wreg     <= bus.ex_wreg;
         r_wdata    <= bus.ex_wdata;
         r_whilo    <= bus.ex_whilo;
         r_hi       <= bus.ex_hi;
         r_lo       <= bus.ex_lo;
         r_hilo_tmp <= 64'd0;
         r_cnt      <= 2'd0;
      end
   end

   assign bus.mem_wd     = r_wd;
   assign bus.mem_wreg   = r_wreg;
   assign bus.mem_wdata  = r_wdata;
   assign bus.mem_whilo  = r_whilo;
   assign bus.mem_hi     = r_hi;
   assign bus.mem_lo     = r_lo;
   assign bus.hilo_tmp_o = r_hilo_tmp;
   assign bus.cnt_o      = r_cnt;
   assign bus.bubble_cnt = r_bub;
endmodule
`default_nettype wire
